// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue stage: ALUCtrl codes, ALUOp classes, funct fields.
// Mul decode and the operand hold counter are enabled by defining ALU_MUL_EN.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_AND  = 3'b001,
        ALU_SLL  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_SUB  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_SRAI = 3'b110,
        ALU_NONE = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        OP_ITYPE  = 2'b00,
        OP_BRANCH = 2'b01,
        OP_RTYPE  = 2'b10,
        OP_RSVD   = 2'b11
    } alu_op_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_AND = 3'b111;

    // srai only uses the low five immediate bits as the shift amount
    function automatic logic [31:0] srai_shamt(input logic [31:0] imm);
        return {27'b0, imm[4:0]};
    endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational ALUOp/funct7/funct3 decoder producing ALUCtrl and operand-select flags.
// With ALU_MUL_EN undefined the mul encoding decodes as illegal and o_is_mul is absent.
module alu_ctrl_dec
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [6:0] i_funct7,
    input  logic [2:0] i_funct3,
    output alu_ctrl_e  o_ctrl,
    output logic       o_use_imm,
    output logic       o_srai_mask,
    output logic       o_illegal
`ifdef ALU_MUL_EN
    ,
    output logic       o_is_mul
`endif
);

    always_comb begin
        o_ctrl      = ALU_NONE;
        o_use_imm   = 1'b0;
        o_srai_mask = 1'b0;
`ifdef ALU_MUL_EN
        o_is_mul    = 1'b0;
`endif
        case (alu_op_e'(i_alu_op))
            OP_ITYPE: begin
                if (i_funct3 == F3_ADD) begin
                    o_ctrl    = ALU_ADD;
                    o_use_imm = 1'b1;
                end else if (i_funct3 == F3_SR && i_funct7 == F7_ALT) begin
                    o_ctrl      = ALU_SRAI;
                    o_use_imm   = 1'b1;
                    o_srai_mask = 1'b1;
                end
            end
            OP_BRANCH: o_ctrl = ALU_SUB;
            OP_RTYPE: begin
                case (i_funct7)
                    F7_BASE: begin
                        case (i_funct3)
                            F3_ADD:  o_ctrl = ALU_ADD;
                            F3_AND:  o_ctrl = ALU_AND;
                            F3_SLL:  o_ctrl = ALU_SLL;
                            F3_XOR:  o_ctrl = ALU_XOR;
                            default: o_ctrl = ALU_NONE;
                        endcase
                    end
                    F7_ALT: begin
                        if (i_funct3 == F3_ADD) o_ctrl = ALU_SUB;
                    end
`ifdef ALU_MUL_EN
                    F7_MULDIV: begin
                        if (i_funct3 == F3_ADD) begin
                            o_ctrl   = ALU_MUL;
                            o_is_mul = 1'b1;
                        end
                    end
`endif
                    default: o_ctrl = ALU_NONE;
                endcase
            end
            default: o_ctrl = ALU_NONE;
        endcase
    end

    assign o_illegal = (o_ctrl == ALU_NONE);

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, operand select and a one-entry ID/EX register with valid/ready.
// Define ALU_MUL_EN to decode mul and hold its operands for MUL_LAT cycles.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned MUL_LAT = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  ALUOp_i,
    input  logic [6:0]  funct7_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic        flush_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic [2:0]  ALUCtrl_o,
    output logic        illegal_o
);

    alu_ctrl_e   w_ctrl;
    logic        w_use_imm;
    logic        w_srai_mask;
    logic        w_illegal;
    logic [31:0] w_data2;
    logic        w_out_valid;
    logic        w_xfer;
    logic        w_cap;

    logic        r_full;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    alu_ctrl_e   r_ctrl;
    logic        r_illegal;

`ifdef ALU_MUL_EN
    localparam int unsigned LP_CNT_W = $clog2(MUL_LAT) + 1;
    logic                w_is_mul;
    logic [LP_CNT_W-1:0] r_cnt;
`endif

    alu_ctrl_dec u_dec (
        .i_alu_op    (ALUOp_i),
        .i_funct7    (funct7_i),
        .i_funct3    (funct3_i),
        .o_ctrl      (w_ctrl),
        .o_use_imm   (w_use_imm),
        .o_srai_mask (w_srai_mask),
        .o_illegal   (w_illegal)
`ifdef ALU_MUL_EN
        ,
        .o_is_mul    (w_is_mul)
`endif
    );

    always_comb begin
        w_data2 = rs2_data_i;
        if (w_use_imm) w_data2 = w_srai_mask ? srai_shamt(imm_i) : imm_i;
    end

    assign w_xfer     = w_out_valid && out_ready_i;
    assign in_ready_o = !r_full || w_xfer;
    // flush wins over a same-cycle capture, but does not gate in_ready_o
    assign w_cap      = in_valid_i && in_ready_o && !flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_full    <= 1'b0;
            r_data1   <= '0;
            r_data2   <= '0;
            r_ctrl    <= ALU_ADD;
            r_illegal <= 1'b0;
        end else if (flush_i) begin
            r_full <= 1'b0;
        end else if (w_cap) begin
            r_full    <= 1'b1;
            r_data1   <= rs1_data_i;
            r_data2   <= w_data2;
            r_ctrl    <= w_ctrl;
            r_illegal <= w_illegal;
        end else if (w_xfer) begin
            r_full <= 1'b0;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (flush_i) begin
            r_cnt <= '0;
        end else if (w_cap) begin
            r_cnt <= w_is_mul ? LP_CNT_W'(MUL_LAT - 1) : '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - LP_CNT_W'(1);
        end
    end

    assign w_out_valid = r_full && (r_cnt == '0);
`else
    // no hold counter; an out-of-range MUL_LAT blocks issue instead of misbehaving
    assign w_out_valid = r_full && (MUL_LAT >= 1);
`endif

    assign out_valid_o = w_out_valid;
    assign data1_o     = r_data1;
    assign data2_o     = r_data2;
    assign ALUCtrl_o   = r_ctrl;
    assign illegal_o   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a transfer scoreboard; follows ALU_MUL_EN
// for the expected mul behaviour.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [6:0] f7;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  ctrl;
    logic        ill;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [2:0]  ctrl;
        logic        ill;
    } exp_t;

    exp_t sbq[$];
    exp_t pend;

    alu_issue_stage #(.MUL_LAT(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ALUOp_i     (alu_op),
        .funct7_i    (f7),
        .funct3_i    (f3),
        .rs1_data_i  (rs1),
        .rs2_data_i  (rs2),
        .imm_i       (imm),
        .flush_i     (flush),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .data1_o     (d1),
        .data2_o     (d2),
        .ALUCtrl_o   (ctrl),
        .illegal_o   (ill)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [6:0] fn7, input logic [2:0] fn3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] e_d2, input logic [2:0] e_ctrl, input logic e_ill);
        alu_op   = op;
        f7       = fn7;
        f3       = fn3;
        rs1      = a;
        rs2      = b;
        imm      = im;
        in_valid = 1'b1;
        pend     = '{d1: a, d2: e_d2, ctrl: e_ctrl, ill: e_ill};
    endtask

    // sampled on the falling edge: retire transfers, then record captures
    task automatic sb();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_xfer", 32'(out_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_data1", d1, e.d1);
                check("sb_data2", d2, e.d2);
                check("sb_ctrl", 32'(ctrl), 32'(e.ctrl));
                check("sb_illegal", 32'(ill), 32'(e.ill));
            end
        end
        if (flush) sbq.delete();
        else if (in_valid && in_ready) sbq.push_back(pend);
    endtask

    task automatic step();
        @(negedge clk);
        sb();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 2'b10;
        f7        = 7'h00;
        f3        = 3'b000;
        rs1       = 32'hDEAD_BEEF;
        rs2       = 32'h1234_5678;
        imm       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        pend      = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data1", d1, 32'd0);
        check("rst_data2", d2, 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd0);
        check("rst_illegal", 32'(ill), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;

        // add, next-cycle latency
        issue(2'b10, 7'b0000000, 3'b000, 32'd5, 32'd7, 32'd0, 32'd7, 3'b000, 1'b0);
        step();
        in_valid = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_ctrl", 32'(ctrl), 32'd0);
        check("add_data2", d2, 32'd7);

        // back-to-back decode patterns at full rate
        issue(2'b10, 7'b0000000, 3'b111, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h0FF0_FFFF, 3'b001, 1'b0);
        step();
        check("and_valid", 32'(out_valid), 32'd1);
        check("and_in_ready", 32'(in_ready), 32'd1);
        issue(2'b10, 7'b0000000, 3'b001, 32'h0000_0001, 32'h0000_001F, 32'h0, 32'h0000_001F, 3'b010, 1'b0);
        step();
        check("sll_valid", 32'(out_valid), 32'd1);
        issue(2'b10, 7'b0000000, 3'b100, 32'hAAAA_5555, 32'h0F0F_0F0F, 32'h0, 32'h0F0F_0F0F, 3'b011, 1'b0);
        step();
        check("xor_ctrl", 32'(ctrl), 32'd3);
        issue(2'b00, 7'b1111111, 3'b000, 32'h0000_0100, 32'h5555_5555, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 3'b000, 1'b0);
        step();
        check("addi_data2", d2, 32'hFFFF_FFF0);
        issue(2'b00, 7'b0100000, 3'b101, 32'h8000_0000, 32'h1111_1111, 32'hFFFF_FFE3, 32'h0000_0003, 3'b110, 1'b0);
        step();
        check("srai_data2", d2, 32'h0000_0003);
        check("srai_ctrl", 32'(ctrl), 32'd6);
        issue(2'b01, 7'b0000000, 3'b000, 32'd9, 32'd4, 32'hFFFF_FFFF, 32'd4, 3'b100, 1'b0);
        step();
        check("beq_ctrl", 32'(ctrl), 32'd4);
        issue(2'b10, 7'b0000000, 3'b010, 32'd1, 32'd2, 32'd3, 32'd2, 3'b111, 1'b1);
        step();
        check("illegal_r_ctrl", 32'(ctrl), 32'd7);
        check("illegal_r_flag", 32'(ill), 32'd1);
        issue(2'b11, 7'b0000000, 3'b000, 32'd6, 32'd8, 32'd10, 32'd8, 3'b111, 1'b1);
        step();
        check("rsvd_op_flag", 32'(ill), 32'd1);
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);

        // mul encoding
`ifdef ALU_MUL_EN
        issue(2'b10, 7'b0000001, 3'b000, 32'd6, 32'd9, 32'd0, 32'd9, 3'b101, 1'b0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            check("mul_hold_valid", 32'(out_valid), 32'd0);
            check("mul_hold_ctrl", 32'(ctrl), 32'd5);
            check("mul_hold_data1", d1, 32'd6);
            check("mul_hold_data2", d2, 32'd9);
            check("mul_hold_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        check("mul_valid", 32'(out_valid), 32'd1);
        check("mul_ctrl", 32'(ctrl), 32'd5);
        check("mul_in_ready", 32'(in_ready), 32'd1);
        step();
        check("mul_done_valid", 32'(out_valid), 32'd0);
`else
        issue(2'b10, 7'b0000001, 3'b000, 32'd6, 32'd9, 32'd0, 32'd9, 3'b111, 1'b1);
        step();
        in_valid = 1'b0;
        check("mul_off_valid", 32'(out_valid), 32'd1);
        check("mul_off_ctrl", 32'(ctrl), 32'd7);
        check("mul_off_illegal", 32'(ill), 32'd1);
        step();
        check("mul_off_done", 32'(out_valid), 32'd0);
`endif

        // backpressure on a sub, then transfer and capture on the same edge
        out_ready = 1'b0;
        issue(2'b10, 7'b0100000, 3'b000, 32'd100, 32'd30, 32'd0, 32'd30, 3'b100, 1'b0);
        step();
        issue(2'b10, 7'b0000000, 3'b100, 32'hAAAA_AAAA, 32'h0F0F_0F0F, 32'd0, 32'h0F0F_0F0F, 3'b011, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ctrl", 32'(ctrl), 32'd4);
            check("bp_data1", d1, 32'd100);
            check("bp_data2", d2, 32'd30);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_ctrl", 32'(ctrl), 32'd3);
        step();

        // flush of a held entry, then flush racing a capture into an empty stage
        out_ready = 1'b0;
        issue(2'b10, 7'b0000000, 3'b000, 32'd1, 32'd2, 32'd0, 32'd2, 3'b000, 1'b0);
        step();
        flush = 1'b1;
        issue(2'b10, 7'b0000000, 3'b001, 32'd3, 32'd4, 32'd0, 32'd4, 3'b010, 1'b0);
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        step();
        check("flush_cap_dropped", 32'(out_valid), 32'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("flush_stays_empty", 32'(out_valid), 32'd0);

        // asynchronous reset while an entry is held
        out_ready = 1'b0;
`ifdef ALU_MUL_EN
        issue(2'b10, 7'b0000001, 3'b000, 32'd11, 32'd13, 32'd0, 32'd13, 3'b101, 1'b0);
        step();
        check("arst_pre_valid", 32'(out_valid), 32'd0);
`else
        issue(2'b10, 7'b0000000, 3'b100, 32'd11, 32'd13, 32'd0, 32'd13, 3'b011, 1'b0);
        step();
        check("arst_pre_valid", 32'(out_valid), 32'd1);
`endif
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_data1", d1, 32'd0);
        check("arst_ctrl", 32'(ctrl), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        sbq.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        issue(2'b10, 7'b0000000, 3'b000, 32'd3, 32'd4, 32'd0, 32'd4, 3'b000, 1'b0);
        step();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data2", d2, 32'd4);
        step();

        check("sb_all_retired", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue stage that drives the ALU: decodes ALUOp/funct fields into the 3-bit ALUCtrl code, selects operands, and holds them in a one-entry ID/EX register with valid/ready handshakes on both sides. For `mul`, operands and control are held stable for MUL_LAT cycles before the result is presented downstream. Sits between the register-file/immediate-generation logic and the ALU.

## Interface
- MUL_LAT, 3, cycles the ALU needs stable operands for `mul` (≥1)
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  upstream has an instruction
- in_ready_o  out  1  stage can capture this cycle
- ALUOp_i  in  2  00 I-type, 01 branch-compare, 10 R-type, 11 reserved
- funct7_i  in  7  instruction[31:25]
- funct3_i  in  3  instruction[14:12]
- rs1_data_i  in  32  register operand 1
- rs2_data_i  in  32  register operand 2
- imm_i  in  32  sign-extended immediate
- flush_i  in  1  discard held entry
- out_ready_i  in  1  EX stage accepts
- out_valid_o  out  1  data1_o/data2_o/ALUCtrl_o valid for transfer
- data1_o  out  32  ALU operand 1
- data2_o  out  32  ALU operand 2
- ALUCtrl_o  out  3  000 add, 001 and, 010 sll, 011 xor, 100 sub, 101 mul, 110 srai, 111 none
- illegal_o  out  1  held entry did not decode

## Operation
- Decode (R-type, ALUOp 10; data2 = rs2): f7 0000000 with f3 000 add, 111 and, 001 sll, 100 xor; f7 0100000/f3 000 sub; f7 0000001/f3 000 mul.
- Decode (I-type, ALUOp 00): f3 000 addi → add, data2 = imm_i; f3 101 with f7 0100000 srai → 110, data2 = {27'b0, imm_i[4:0]}.
- ALUOp 01 → sub, data2 = rs2. Anything else → ALUCtrl 111, illegal_o=1, data2 = rs2; entry still flows through.
- data1_o = rs1_data_i always.
- Entry register: full flag plus hold counter cnt (width $clog2(MUL_LAT)+1). On capture, cnt ← MUL_LAT-1 for mul, else 0.
- cnt decrements each cycle while nonzero; out_valid_o = full && cnt==0.
- Capture: in_valid_i && in_ready_o. Transfer: out_valid_o && out_ready_i.
- in_ready_o = !full || (out_valid_o && out_ready_i) (combinational pass-through, back-to-back at full rate).
- Simultaneous transfer and capture: new entry replaces old, full stays 1.
- flush_i: full←0, cnt←0 next edge; any capture in the same cycle is dropped (flush wins); in_ready_o unaffected.
- Outputs hold while out_valid_o && !out_ready_i (no change to data/ctrl until transfer).

## Timing
- Reset (async assert, sync release): full=0, cnt=0, out_valid_o=0, data1_o=data2_o=0, ALUCtrl_o=000, illegal_o=0.
- Latency non-mul: capture at edge N → out_valid_o high in cycle N+1.
- Latency mul: capture at edge N → out_valid_o high in cycle N+MUL_LAT; ALUCtrl_o=101 and operands stable all MUL_LAT cycles.
- MUL_LAT=1: mul behaves identically to non-mul.
- Reset asserted mid-hold: entry lost, counter cleared immediately.
- Throughput: 1 op/cycle non-mul; 1 op per MUL_LAT cycles for consecutive mul.

## Configuration
- ALU_MUL_EN defined: mul decoded as above with MUL_LAT hold.
- Undefined: f7 0000001/f3 000 decodes as illegal (ALUCtrl 111, illegal_o=1, cnt loaded 0); counter logic omitted and MUL_LAT ignored.

## Structure
- Shared package alu_pkg: ALUCtrl encodings, ALUOp codes, funct7/funct3 constants.
- One combinational sub-module alu_ctrl_dec (ALUOp/funct7/funct3 → ALUCtrl, imm-select, srai-mask, illegal, is_mul); the entry register, counter, and handshake are in the top.

## Test plan
- Reset mid-stream: hold rst_i=0 → all outputs 0, in_ready_o=1; release, issue add rs1=5 rs2=7 → next cycle out_valid_o=1, ALUCtrl_o=000, data2_o=7.
- srai: ALUOp=00, f7=0100000, f3=101, imm_i=32'hFFFF_FFE3 → data2_o=32'h0000_0003, ALUCtrl_o=110.
- mul with MUL_LAT=3 and out_ready_i=1: capture at edge 0 → out_valid_o low cycles 1–2, high in cycle 3, operands stable throughout, in_ready_o low until transfer.
- Backpressure: out_ready_i=0 for 4 cycles after a sub → outputs frozen, in_ready_o=0; raise out_ready_i with in_valid_i=1 → transfer and capture on the same edge.
- Flush with simultaneous capture: flush_i=1, in_valid_i=1 → next cycle out_valid_o=0, new op dropped.
- Illegal: ALUOp=10, f7=0000000, f3=010 → ALUCtrl_o=111, illegal_o=1; without ALU_MUL_EN, a mul encoding gives the same result after 1 cycle.
